// File: rtl/divider_8.sv
// divider_8: sequential 8-bit restoring divider with one shift-subtract step
// per clock, leaving quotient and remainder in registers that also feed four
// seven-segment decoders.
// Optional build macro DIV_SIGNED_EN: two's-complement operands, with an extra
// FIX cycle that restores the result signs.
module divider_8 (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] S,
    input  logic       Run,
    input  logic       LoadQ,
    output logic [7:0] Qval,
    output logic [7:0] Rval,
    output logic       Busy,
    output logic       Done,
    output logic       DivZero,
    output logic [6:0] QhexU,
    output logic [6:0] QhexL,
    output logic [6:0] RhexU,
    output logic [6:0] RhexL
);

`ifdef DIV_SIGNED_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2, FIX = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t     state_reg;
    logic [7:0] q_reg;
    logic [7:0] r_reg;
    logic [7:0] d_reg;
    logic [3:0] count_reg;
    logic       done_reg;
    logic       divzero_reg;

`ifdef DIV_SIGNED_EN
    logic       neg_q_reg;   // quotient must be negated in FIX
    logic       neg_r_reg;   // remainder must be negated in FIX
`endif

    // Operands as they enter the iteration: magnitudes when signed
    logic [7:0] dividend_start;
    logic [7:0] divisor_start;

    // One restoring step: shift the next dividend bit into the partial remainder
    logic [8:0] p;
    logic [9:0] t;
    logic       t_neg;

    // 7-segment decode of each displayed nibble, active-low segments {g..a}
    logic [15:0] nibbles;
    logic [6:0]  seg [4];

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        s = 7'b1000000;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    // Select the operands used at the start edge
    always_comb begin
        dividend_start = q_reg;
        divisor_start  = S;
`ifdef DIV_SIGNED_EN
        if (q_reg[7]) dividend_start = 8'd0 - q_reg;
        if (S[7])     divisor_start  = 8'd0 - S;
`endif
    end

    // Trial subtraction; any bit above the remainder width set means P < D
    always_comb begin
        p     = {r_reg, q_reg[7]};
        t     = {1'b0, p} - {2'b00, d_reg};
        t_neg = (t[9:8] != 2'b00);
    end

    // Control FSM and datapath registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= IDLE;
            q_reg       <= 8'd0;
            r_reg       <= 8'd0;
            d_reg       <= 8'd0;
            count_reg   <= 4'd0;
            done_reg    <= 1'b0;
            divzero_reg <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (LoadQ) begin
                        q_reg       <= S;
                        r_reg       <= 8'd0;
                        divzero_reg <= 1'b0;
                        done_reg    <= 1'b0;
                        state_reg   <= IDLE;
                    end else if (state_reg == IDLE && Run) begin
                        if (S == 8'd0) begin
                            // Divide by zero: raw dividend bits go to R
                            q_reg       <= 8'hFF;
                            r_reg       <= q_reg;
                            divzero_reg <= 1'b1;
                            done_reg    <= 1'b1;
                            state_reg   <= DONE;
                        end else begin
                            q_reg       <= dividend_start;
                            d_reg       <= divisor_start;
                            r_reg       <= 8'd0;
                            count_reg   <= 4'd0;
                            divzero_reg <= 1'b0;
`ifdef DIV_SIGNED_EN
                            neg_q_reg   <= q_reg[7] ^ S[7];
                            neg_r_reg   <= q_reg[7];
`endif
                            state_reg   <= CALC;
                        end
                    end else if (state_reg == DONE && !Run) begin
                        // Holding Run keeps DONE so a division never restarts
                        done_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                CALC: begin
                    if (t_neg) begin
                        r_reg <= p[7:0];
                        q_reg <= {q_reg[6:0], 1'b0};
                    end else begin
                        r_reg <= t[7:0];
                        q_reg <= {q_reg[6:0], 1'b1};
                    end
                    count_reg <= count_reg + 4'd1;
                    if (count_reg == 4'd7) begin
`ifdef DIV_SIGNED_EN
                        state_reg <= FIX;
`else
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
`endif
                    end
                end
`ifdef DIV_SIGNED_EN
                FIX: begin
                    if (neg_q_reg) q_reg <= 8'd0 - q_reg;
                    if (neg_r_reg) r_reg <= 8'd0 - r_reg;
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef DIV_SIGNED_EN
    assign Busy = (state_reg == CALC) || (state_reg == FIX);
`else
    assign Busy = (state_reg == CALC);
`endif

    assign Qval    = q_reg;
    assign Rval    = r_reg;
    assign Done    = done_reg;
    assign DivZero = divzero_reg;

    // Nibble order, low to high: RhexL, RhexU, QhexL, QhexU
    assign nibbles = {Qval, Rval};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hex
            assign seg[gi] = hex7(nibbles[gi*4 +: 4]);
        end
    endgenerate

    assign RhexL = seg[0];
    assign RhexU = seg[1];
    assign QhexL = seg[2];
    assign QhexU = seg[3];

endmodule

// File: doc/divider_8.md
# divider_8

Sequential 8-bit restoring divider for the lab board, the inverse datapath of the existing 8-bit shift-add multiplier. A dividend is loaded from the switches into the quotient register. The divisor is sampled from the switches when Run is seen. The block then performs one shift-subtract iteration per clock and leaves the quotient and remainder in registers. Both registers drive the seven-segment displays through the existing HexDriver decoder. The block sits behind the board's button/switch synchronizers: all inputs arrive synchronized and active-high.

## Interface
- No parameters; width fixed at 8.
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high; clears all state.
- S  in  8  switch value; dividend on LoadQ, divisor on Run.
- Run  in  1  level request to start a division.
- LoadQ  in  1  level request to load the dividend.
- Qval  out  8  quotient register.
- Rval  out  8  remainder register.
- Busy  out  1  high while a division is in progress.
- Done  out  1  high in DONE state.
- DivZero  out  1  last division had divisor 0.
- QhexU, QhexL, RhexU, RhexL  out  7 each  HexDriver decodes of Qval[7:4], Qval[3:0], Rval[7:4], Rval[3:0].

## Operation
- States: IDLE, CALC, FIX (present only with DIV_SIGNED_EN), DONE.
- IDLE and DONE both accept LoadQ.
  - On LoadQ: Q<=S, R<=0, DivZero<=0, Done<=0; state becomes IDLE.
  - LoadQ has priority over Run in the same cycle; Run is then ignored for that cycle.
- IDLE with Run=1 and LoadQ=0: D<=S, R<=0, count<=0, state becomes CALC.
- Divisor zero at the same edge: no CALC. Instead Q<=8'hFF, R<=dividend, DivZero<=1, state becomes DONE.
- CALC iteration, one per cycle:
  - P = {R, Q[7]}, 9 bits.
  - T = P - {1'b0, D}, 10-bit arithmetic.
  - If T is non-negative: R<=T[7:0] and Q<={Q[6:0],1}.
  - Otherwise: R<=P[7:0] and Q<={Q[6:0],0}. P < D ≤ 255 here, so no truncation occurs.
  - count increments each iteration.
  - After the 8th iteration, state becomes DONE (FIX if signed).
- DONE: Done=1. The state is held while Run=1, so holding Run never restarts a division. Run=0 returns the block to IDLE, which keeps Q and R.
- Run, LoadQ and S changes are ignored in CALC and FIX.
- Reset, at any state including mid-CALC: Q, R, D and count become 0, state becomes IDLE, and Busy, Done and DivZero become 0.
- Busy = state is CALC or FIX.

## Timing
- Run sampled high in IDLE at edge k:
  - Busy is high after edge k.
  - Iterations occur at edges k+1..k+8.
  - Done is high after edge k+8 (unsigned) or k+9 (signed).
- Divide-by-zero: Done and DivZero are high after edge k. Busy never asserts.
- LoadQ takes effect at the edge where it is sampled; Qval updates immediately after that edge.
- Hex outputs are combinational from Qval and Rval.
- Reset values: Qval=Rval=0; Busy=Done=DivZero=0; all hex outputs equal the HexDriver encoding of 0.

## Configuration
- Macro: DIV_SIGNED_EN.
- Defined: operands are two's complement.
  - At the start edge, the absolute values of the dividend and divisor are used, and their signs are latched.
  - FIX state, one cycle: Q is negated if the signs differ; R is negated if the dividend is negative.
  - Result: quotient truncates toward zero; remainder takes the dividend's sign.
  - -128 / -1 yields Q=8'h80, R=0; there is no overflow flag.
  - Divide-by-zero behaves as unsigned: Q=FF and R=original dividend bits.
- Undefined: unsigned operation only. FIX state and sign logic are absent, and latency is 8 iterations.

## Test plan
- Unsigned divide: LoadQ with S=8'd100, then Run with S=8'd7. Required: Busy for 8 cycles, then Done, Qval=8'd14, Rval=8'd2, QhexU/QhexL show "0E", RhexU/RhexL show "02".
- Edge values: 255/1 → Q=FF, R=00. 3/200 → Q=00, R=03. 255/255 → Q=01, R=00.
- Divide by zero: dividend 8'h2A, divisor 0. Required: DivZero=1 and Done=1 one cycle after Run, Q=FF, R=2A, Busy never high.
- Reset and hold behaviour:
  - Reset asserted at the 4th CALC cycle: next cycle is IDLE with all outputs 0.
  - A subsequent 100/7 division completes correctly.
  - Run held high for 20 cycles after Done: no restart; Q and R remain stable.
  - LoadQ pulsed during CALC: ignored; result is unchanged.
- Signed (DIV_SIGNED_EN): -100/7 (8'h9C/8'h07) → Q=8'hF2, R=8'hFE. 100/-7 → Q=F2, R=02. Done is high 9 edges after the Run sample edge.
